// File: rtl/mem_port_arbiter_if.sv
// Avalon-MM-style memory master bus shared by the Dijkstra accelerator requesters.
// The master modport is the arbiter side; the slave modport is the memory side.
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 32
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

interface mem_port_arbiter_if #(
  parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
);
  logic [MADDR_WIDTH-1:0] mem_addr;
  logic                   mem_read;
  logic                   mem_write;
  logic [MDATA_WIDTH-1:0] mem_write_data;
  logic [MDATA_WIDTH-1:0] mem_read_data;
  logic                   mem_read_data_valid;
  logic                   mem_wait_request;

  modport master (
    output mem_addr, mem_read, mem_write, mem_write_data,
    input  mem_read_data, mem_read_data_valid, mem_wait_request
  );

  modport slave (
    input  mem_addr, mem_read, mem_write, mem_write_data,
    output mem_read_data, mem_read_data_valid, mem_wait_request
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory master port among NUM_REQ requesters,
// one transaction in flight. Optional watchdog abort enabled by ARB_TIMEOUT_EN.
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 32
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

module mem_port_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int MADDR_WIDTH    = `DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH    = `DEFAULT_MDATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*MADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*MDATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             req_done,
  output logic [MDATA_WIDTH-1:0]         req_rdata,
  output logic                           req_error,
  output logic [NUM_REQ-1:0]             grant,
  mem_port_arbiter_if.master             mem,
  output logic                           busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RDATA, S_DONE} state_t;

  state_t                 r_state, w_state;
  logic [IDX_W-1:0]       r_last, w_last;
  logic [NUM_REQ-1:0]     r_grant, w_grant;
  logic                   r_write, w_write;
  logic [MADDR_WIDTH-1:0] r_addr, w_addr;
  logic [MDATA_WIDTH-1:0] r_wdata, w_wdata;
  logic                   r_read_cmd, w_read_cmd;
  logic                   r_write_cmd, w_write_cmd;
  logic [NUM_REQ-1:0]     r_done, w_done;
  logic [MDATA_WIDTH-1:0] r_rdata, w_rdata;
  logic                   w_err_next;
  logic                   w_to_hit;

  logic                   w_found;
  logic [IDX_W-1:0]       w_pick;

  // Search starts just past the last owner, so a requester still pending after
  // its own completion loses to everyone else who is waiting.
  always_comb begin : rr_search
    int               idx;
    logic [IDX_W-1:0] idx_b;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = 0;
    idx_b   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(r_last) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_b = IDX_W'(idx);
      if (!w_found && req_valid[idx_b]) begin
        w_found = 1'b1;
        w_pick  = idx_b;
      end
    end
  end

  always_comb begin
    w_state     = r_state;
    w_last      = r_last;
    w_grant     = r_grant;
    w_write     = r_write;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_read_cmd  = r_read_cmd;
    w_write_cmd = r_write_cmd;
    w_done      = '0;
    w_rdata     = r_rdata;
    w_err_next  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant     = NUM_REQ'(1) << w_pick;
          w_last      = w_pick;
          w_write     = req_write[w_pick];
          w_addr      = req_addr[int'(w_pick)*MADDR_WIDTH +: MADDR_WIDTH];
          w_wdata     = req_wdata[int'(w_pick)*MDATA_WIDTH +: MDATA_WIDTH];
          w_read_cmd  = ~req_write[w_pick];
          w_write_cmd = req_write[w_pick];
          w_state     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (!mem.mem_wait_request && r_write) begin
          w_write_cmd = 1'b0;
          w_done      = r_grant;
          w_state     = S_DONE;
        end else if (!mem.mem_wait_request && mem.mem_read_data_valid) begin
          // Zero-latency slave: data returns on the accept edge itself.
          w_read_cmd = 1'b0;
          w_rdata    = mem.mem_read_data;
          w_done     = r_grant;
          w_state    = S_DONE;
        end else if (w_to_hit) begin
          w_read_cmd  = 1'b0;
          w_write_cmd = 1'b0;
          w_done      = r_grant;
          w_err_next  = 1'b1;
          w_state     = S_DONE;
        end else if (!mem.mem_wait_request) begin
          w_read_cmd = 1'b0;
          w_state    = S_WAIT_RDATA;
        end
      end

      S_WAIT_RDATA: begin
        if (mem.mem_read_data_valid) begin
          w_rdata = mem.mem_read_data;
          w_done  = r_grant;
          w_state = S_DONE;
        end else if (w_to_hit) begin
          w_done     = r_grant;
          w_err_next = 1'b1;
          w_state    = S_DONE;
        end
      end

      S_DONE: begin
        w_grant = '0;
        w_state = S_IDLE;
      end

      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last      <= IDX_W'(NUM_REQ-1);
      r_grant     <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_read_cmd  <= 1'b0;
      r_write_cmd <= 1'b0;
      r_done      <= '0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state;
      r_last      <= w_last;
      r_grant     <= w_grant;
      r_write     <= w_write;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_read_cmd  <= w_read_cmd;
      r_write_cmd <= w_write_cmd;
      r_done      <= w_done;
      r_rdata     <= w_rdata;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_to_cnt;
  logic             r_error;

  // Counter is zero on the first ISSUE cycle, so the abort edge lands after
  // exactly TIMEOUT_CYCLES cycles spent in ISSUE/WAIT_RDATA.
  assign w_to_hit = (r_state == S_ISSUE || r_state == S_WAIT_RDATA) &&
                    (r_to_cnt == CNT_W'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_to_cnt <= '0;
      r_error  <= 1'b0;
    end else begin
      r_error <= w_err_next;
      if (r_state == S_ISSUE || r_state == S_WAIT_RDATA) r_to_cnt <= r_to_cnt + 1'b1;
      else                                                r_to_cnt <= '0;
    end
  end

  assign req_error = r_error;
`else
  logic w_unused_timeout;

  assign w_to_hit         = 1'b0;
  assign w_unused_timeout = w_err_next ^ (TIMEOUT_CYCLES != 0);
  assign req_error        = 1'b0;
`endif

  assign grant              = r_grant;
  assign req_done           = r_done;
  assign req_rdata          = r_rdata;
  assign busy               = (r_state != S_IDLE);
  assign mem.mem_addr       = r_addr;
  assign mem.mem_write_data = r_wdata;
  assign mem.mem_read       = r_read_cmd;
  assign mem.mem_write      = r_write_cmd;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with three requesters and 16-bit bus;
// the watchdog section only runs when ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module tb_mem_port_arbiter;
  localparam int NR = 3;
  localparam int AW = 16;
  localparam int DW = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_write = '0;
  logic [NR*AW-1:0]  req_addr  = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR-1:0]     req_done;
  logic [DW-1:0]     req_rdata;
  logic              req_error;
  logic [NR-1:0]     grant;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter_if #(.MADDR_WIDTH(AW), .MDATA_WIDTH(DW)) mif ();

  mem_port_arbiter #(
    .NUM_REQ(NR), .MADDR_WIDTH(AW), .MDATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_rdata(req_rdata), .req_error(req_error),
    .grant(grant), .mem(mif), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i]         = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_rd"},    32'(mif.mem_read), 0);
    chk({tag, "_wr"},    32'(mif.mem_write), 0);
    chk({tag, "_addr"},  32'(mif.mem_addr), 0);
    chk({tag, "_wdata"}, 32'(mif.mem_write_data), 0);
    chk({tag, "_done"},  32'(req_done), 0);
    chk({tag, "_rdata"}, 32'(req_rdata), 0);
    chk({tag, "_err"},   32'(req_error), 0);
    chk({tag, "_busy"},  32'(busy), 0);
  endtask

  initial begin
    int exp_g [6];
    exp_g = '{0, 1, 2, 0, 1, 2};
    mif.mem_read_data       = '0;
    mif.mem_read_data_valid = 1'b0;
    mif.mem_wait_request    = 1'b0;

    // Reset state
    tick(); tick();
    chk_all_zero("rst");
    reset = 1'b0;
    tick();

    // Single write by requester 1, no stall
    set_req(1, 1'b1, 16'h0040, 16'h1234);
    req_valid = 3'b010;
    tick();
    chk("wr_issue_cmd",   32'(mif.mem_write), 1);
    chk("wr_issue_rd",    32'(mif.mem_read), 0);
    chk("wr_issue_addr",  32'(mif.mem_addr), 32'h40);
    chk("wr_issue_data",  32'(mif.mem_write_data), 32'h1234);
    chk("wr_issue_grant", 32'(grant), 32'b010);
    chk("wr_issue_done",  32'(req_done), 0);
    tick();
    chk("wr_done_cmd",  32'(mif.mem_write), 0);
    chk("wr_done",      32'(req_done), 32'b010);
    chk("wr_done_err",  32'(req_error), 0);
    tick();
    req_valid = '0;
    chk("wr_idle_done",  32'(req_done), 0);
    chk("wr_idle_grant", 32'(grant), 0);
    chk("wr_idle_busy",  32'(busy), 0);

    // Single read by requester 0, data one cycle after accept
    set_req(0, 1'b0, 16'h0010, 16'h0000);
    req_valid = 3'b001;
    tick();
    chk("rd_issue_cmd",  32'(mif.mem_read), 1);
    chk("rd_issue_addr", 32'(mif.mem_addr), 32'h10);
    tick();
    chk("rd_wait_cmd",  32'(mif.mem_read), 0);
    chk("rd_wait_done", 32'(req_done), 0);
    mif.mem_read_data       = 16'hBEEF;
    mif.mem_read_data_valid = 1'b1;
    tick();
    mif.mem_read_data_valid = 1'b0;
    chk("rd_done",       32'(req_done), 32'b001);
    chk("rd_done_rdata", 32'(req_rdata), 32'hBEEF);
    tick();
    req_valid = '0;
    chk("rd_idle_done", 32'(req_done), 0);

    // Contention from reset: all three pending continuously
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(16'h0100 + i), DW'(16'hA000 + i));
    req_valid = 3'b111;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk($sformatf("rr_grant%0d", t), 32'(grant), 32'(1 << exp_g[t]));
      chk($sformatf("rr_addr%0d", t),  32'(mif.mem_addr), 32'(16'h0100 + exp_g[t]));
      tick();
      chk($sformatf("rr_done%0d", t),  32'(req_done), 32'(1 << exp_g[t]));
      tick();
    end
    req_valid = '0;

    // Write stalled for 5 cycles; late address change must not leak through
    mif.mem_wait_request = 1'b1;
    set_req(1, 1'b1, 16'h0080, 16'h5A5A);
    req_valid = 3'b010;
    tick();
    set_req(1, 1'b1, 16'h00FF, 16'hFFFF);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("st_cmd%0d", k),  32'(mif.mem_write), 1);
      chk($sformatf("st_addr%0d", k), 32'(mif.mem_addr), 32'h80);
      chk($sformatf("st_data%0d", k), 32'(mif.mem_write_data), 32'h5A5A);
      chk($sformatf("st_done%0d", k), 32'(req_done), 0);
      if (k < 4) tick();
    end
    mif.mem_wait_request = 1'b0;
    chk("st_rel_cmd",  32'(mif.mem_write), 1);
    chk("st_rel_addr", 32'(mif.mem_addr), 32'h80);
    tick();
    chk("st_done",     32'(req_done), 32'b010);
    chk("st_done_cmd", 32'(mif.mem_write), 0);
    tick();
    req_valid = '0;

    // Reset while waiting for read data
    set_req(2, 1'b0, 16'h0022, 16'h0000);
    req_valid = 3'b100;
    tick();
    chk("rm_issue_grant", 32'(grant), 32'b100);
    tick();
    chk("rm_wait_busy", 32'(busy), 1);
    reset = 1'b1;
    req_valid = '0;
    tick();
    chk_all_zero("rm_rst");
    reset = 1'b0;
    mif.mem_read_data       = 16'hDEAD;
    mif.mem_read_data_valid = 1'b1;
    tick();
    mif.mem_read_data_valid = 1'b0;
    chk("rm_late_done",  32'(req_done), 0);
    chk("rm_late_rdata", 32'(req_rdata), 0);
    chk("rm_late_busy",  32'(busy), 0);
    set_req(2, 1'b0, 16'h0023, 16'h0000);
    req_valid = 3'b100;
    tick();
    chk("rm_new_grant", 32'(grant), 32'b100);
    chk("rm_new_cmd",   32'(mif.mem_read), 1);
    chk("rm_new_addr",  32'(mif.mem_addr), 32'h23);
    tick();
    mif.mem_read_data       = 16'hCAFE;
    mif.mem_read_data_valid = 1'b1;
    tick();
    mif.mem_read_data_valid = 1'b0;
    chk("rm_new_done",  32'(req_done), 32'b100);
    chk("rm_new_rdata", 32'(req_rdata), 32'hCAFE);
    tick();
    req_valid = '0;

    // Read data valid on the accept edge goes straight to DONE
    set_req(0, 1'b0, 16'h0030, 16'h0000);
    req_valid = 3'b001;
    tick();
    mif.mem_read_data       = 16'h7777;
    mif.mem_read_data_valid = 1'b1;
    tick();
    mif.mem_read_data_valid = 1'b0;
    chk("ae_done",  32'(req_done), 32'b001);
    chk("ae_rdata", 32'(req_rdata), 32'h7777);
    chk("ae_cmd",   32'(mif.mem_read), 0);
    tick();
    req_valid = '0;

    // A write completion leaves the last read data in place
    set_req(1, 1'b1, 16'h0050, 16'h9999);
    req_valid = 3'b010;
    tick(); tick();
    chk("wk_done",  32'(req_done), 32'b010);
    chk("wk_rdata", 32'(req_rdata), 32'h7777);
    tick();
    req_valid = '0;

`ifdef ARB_TIMEOUT_EN
    // Read with no data return is aborted after 16 cycles
    set_req(0, 1'b0, 16'h0060, 16'h0000);
    req_valid = 3'b001;
    tick();
    for (int k = 0; k < 15; k++) tick();
    chk("to_pre_done", 32'(req_done), 0);
    chk("to_pre_busy", 32'(busy), 1);
    tick();
    chk("to_done",  32'(req_done), 32'b001);
    chk("to_err",   32'(req_error), 1);
    chk("to_rdata", 32'(req_rdata), 32'h7777);
    set_req(1, 1'b1, 16'h0070, 16'h4321);
    req_valid = 3'b010;
    tick();
    chk("to_err_clr", 32'(req_error), 0);
    tick();
    chk("to_next_grant", 32'(grant), 32'b010);
    chk("to_next_addr",  32'(mif.mem_addr), 32'h70);
    tick();
    chk("to_next_done", 32'(req_done), 32'b010);
    chk("to_next_err",  32'(req_error), 0);
    tick();
    req_valid = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory master port of the Dijkstra accelerator between NUM_REQ requesters: graph/edge reader, distance loader, prev-vector writer.
- Round-robin arbitration, one outstanding transaction at a time.
- Drives an Avalon-MM-style master interface (address, read, write, waitrequest, readdatavalid).
- Returns read data and a completion pulse to the granted requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- MADDR_WIDTH, `DEFAULT_MADDR_WIDTH, memory address width
- MDATA_WIDTH, `DEFAULT_MDATA_WIDTH, memory data width
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with ARB_TIMEOUT_EN)

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request; held until req_done
- req_write  input  NUM_REQ  1=write, 0=read, per requester
- req_addr  input  NUM_REQ*MADDR_WIDTH  flattened addresses; requester i occupies slice [i*MADDR_WIDTH +: MADDR_WIDTH]
- req_wdata  input  NUM_REQ*MDATA_WIDTH  flattened write data
- req_done  output  NUM_REQ  one-hot, one-cycle completion pulse
- req_rdata  output  MDATA_WIDTH  read data, valid with req_done
- req_error  output  1  transaction aborted by timeout, valid with req_done
- grant  output  NUM_REQ  one-hot, current owner; 0 in IDLE
- mem_addr  output  MADDR_WIDTH  master address
- mem_read  output  1  read command
- mem_write  output  1  write command
- mem_write_data  output  MDATA_WIDTH  write data
- mem_read_data  input  MDATA_WIDTH  read return data
- mem_read_data_valid  input  1  read return strobe
- mem_wait_request  input  1  slave stall; command held while high
- busy  output  1  high when state is not IDLE

Behaviour:
- Reset
  - All outputs 0: mem_read, mem_write, mem_addr, mem_write_data, grant, req_done, req_rdata, req_error, busy.
  - State = IDLE; round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.
  - A reset mid-transaction abandons the transaction. No req_done is issued; requesters must reissue.
- States: IDLE, ISSUE, WAIT_RDATA, DONE.
- IDLE
  - Search req_valid starting at index (last+1) mod NUM_REQ, wrapping; pick the first set bit g.
  - If none are set, stay in IDLE.
  - Otherwise, on the clock edge: grant <= onehot(g); last <= g; latch addr, wdata, write of g; go to ISSUE.
  - From this edge mem_read = ~write or mem_write = write is registered high.
- ISSUE
  - Hold mem_addr, mem_write_data and the command stable while mem_wait_request = 1.
  - At the first edge with mem_wait_request = 0, deassert mem_read/mem_write.
  - Write: go to DONE.
  - Read: go to WAIT_RDATA. If mem_read_data_valid is already high at that edge, capture the data and go directly to DONE.
- WAIT_RDATA: on mem_read_data_valid = 1, req_rdata <= mem_read_data, then go to DONE.
- DONE
  - req_done = grant for exactly one cycle; grant cleared on exit; return to IDLE.
  - req_rdata holds its value until the next read completes. Writes do not change it.
- Latency from req_valid to req_done:
  - Write with no stall: 3 cycles.
  - Read with no stall and readdatavalid one cycle after accept: 4 cycles.
- Requester rules
  - The requester drops req_valid in the cycle after req_done.
  - A request still high when the arbiter is back in IDLE is treated as new, but the round-robin rotation means it loses to any other pending requester.
  - Changing req_addr/req_wdata/req_write while granted has no effect; values are latched in IDLE.
- Starvation: with all NUM_REQ requesters continuously pending, each is served once per NUM_REQ transactions.
- Illegal input: mem_read_data_valid outside WAIT_RDATA and the ISSUE accept edge is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined
  - A counter clears on entry to ISSUE and increments every cycle in ISSUE or WAIT_RDATA.
  - When it reaches TIMEOUT_CYCLES-1: deassert the command, go to DONE, req_error = 1 with req_done, req_rdata unchanged.
- Undefined
  - No counter is built; req_error is tied to 0.
  - The arbiter waits indefinitely.

Test Plan:
- Single write: req_valid[1]=1, write=1, addr=0x40, wdata=0x1234, no stall -> mem_write high for exactly one cycle with addr 0x40 and data 0x1234; req_done=2'b10 three cycles after request.
- Single read: req_valid[0], addr=0x10, readdatavalid one cycle after accept with data 0xBEEF -> req_rdata=0xBEEF, req_done=2'b01, 4-cycle latency.
- Contention: NUM_REQ=3, all requesters held high for 6 transactions from reset -> grant order 0,1,2,0,1,2; no back-to-back grant to the same requester.
- Stall: mem_wait_request high for 5 cycles during a write -> mem_addr, data and mem_write stable for all 6 cycles; one write issued; req_done follows the release.
- Reset mid-read: reset asserted in WAIT_RDATA -> next cycle all outputs 0, no req_done; a late readdatavalid is ignored; a fresh request afterwards completes normally.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): read with readdatavalid never asserted -> req_done with req_error=1 after 16 cycles in ISSUE/WAIT_RDATA; the arbiter then serves the next requester.
